// File: rtl/ysyx_regfile_sb_pkg.sv
// Shared constants and types for the scoreboarded integer register file.
package ysyx_regfile_sb_pkg;

  localparam int unsigned DEF_XLEN  = 32;
  localparam int unsigned DEF_NREGS = 32;
  localparam int unsigned DEF_NRD   = 2;
  localparam int unsigned DEF_CNT_W = 2;

  // Architectural register indices with special meaning.
  localparam int unsigned REG_ZERO = 0;
  localparam int unsigned REG_A0   = 10;
  localparam int unsigned REG_A5   = 15;

  // Status of one register's pending-write counter.
  typedef struct packed {
    logic busy;  // at least one reservation outstanding
    logic last;  // exactly one reservation outstanding
    logic full;  // counter saturated, no further reservations
  } sb_stat_t;

  // Register address width; never below one bit.
  function automatic int unsigned addr_width(input int unsigned nregs);
    return (nregs > 1) ? $clog2(nregs) : 1;
  endfunction

endpackage

// File: rtl/ysyx_sb_counter.sv
// Pending-write counter for one architectural register.
module ysyx_sb_counter
  import ysyx_regfile_sb_pkg::*;
#(
  parameter int unsigned CNT_W = DEF_CNT_W
) (
  input  logic     clk,
  input  logic     rst,
  input  logic     inc_i,
  input  logic     dec_i,
  input  logic     flush_i,
  output sb_stat_t stat_o
);

  localparam logic [CNT_W-1:0] CntMax = '1;

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             dec_ok;

  // A release with nothing outstanding is ignored rather than wrapping.
  assign dec_ok = dec_i & (cnt_q != '0);

  // Next count: flush wins, a simultaneous reserve and release cancel out.
  always_comb begin
    cnt_d = cnt_q;
    if (flush_i) begin
      cnt_d = '0;
    end else if (inc_i && !dec_ok) begin
      cnt_d = cnt_q + 1'b1;
    end else if (dec_ok && !inc_i) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  // Counter state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign stat_o.busy = (cnt_q != '0);
  assign stat_o.last = (cnt_q == CNT_W'(1));
  assign stat_o.full = (cnt_q == CntMax);

endmodule

// File: rtl/ysyx_regfile_sb.sv
// Integer register file with bypassed read ports and a per-register
// pending-write scoreboard sitting between issue and writeback.
module ysyx_regfile_sb
  import ysyx_regfile_sb_pkg::*;
#(
  parameter int unsigned XLEN  = DEF_XLEN,
  parameter int unsigned NREGS = DEF_NREGS,
  parameter int unsigned AW    = addr_width(NREGS),
  parameter int unsigned NRD   = DEF_NRD,
  parameter int unsigned CNT_W = DEF_CNT_W
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NRD*AW-1:0]   i_raddr,
  output logic [NRD*XLEN-1:0] o_rdata,
  output logic [NRD-1:0]      o_raw,
  input  logic                i_issue_valid,
  input  logic [AW-1:0]       i_issue_rd,
  output logic                o_issue_ready,
  input  logic                i_wb_wen,
  input  logic [AW-1:0]       i_wb_addr,
  input  logic [XLEN-1:0]     i_wb_data,
  input  logic                i_wb_release,
  input  logic                i_flush,
  input  logic                i_mret,
  output logic [XLEN-1:0]     o_mret_a5,
  output logic                o_a0_zero,
  output logic                o_busy_any
);

  logic [XLEN-1:0]  rf_q [NREGS];
  logic [NREGS-1:0] busy_vec, last_vec, full_vec;
  logic             wb_en, rel_en, issue_fire;

  // x0 is a hard zero: writes and releases aimed at it are dropped.
  assign wb_en      = i_wb_wen & (i_wb_addr != AW'(REG_ZERO));
  assign rel_en     = i_wb_wen & i_wb_release;
  assign issue_fire = i_issue_valid & o_issue_ready;

  // x0 never holds a reservation.
  assign busy_vec[0] = 1'b0;
  assign last_vec[0] = 1'b0;
  assign full_vec[0] = 1'b0;

  for (genvar r = 1; r < NREGS; r++) begin : g_cnt
    sb_stat_t st;

    ysyx_sb_counter #(
      .CNT_W (CNT_W)
    ) u_cnt (
      .clk     (clk),
      .rst     (rst),
      .inc_i   (issue_fire & (i_issue_rd == AW'(r))),
      .dec_i   (rel_en & (i_wb_addr == AW'(r))),
      .flush_i (i_flush),
      .stat_o  (st)
    );

    assign busy_vec[r] = st.busy;
    assign last_vec[r] = st.last;
    assign full_vec[r] = st.full;
  end

  // Architectural array; entry 0 is never written so it always reads zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREGS; i++) begin
        rf_q[i] <= '0;
      end
    end else if (wb_en) begin
      rf_q[i_wb_addr] <= i_wb_data;
    end
  end

  // Read ports: combinational, with same-cycle writeback bypass.
  for (genvar k = 0; k < NRD; k++) begin : g_rd
    logic [AW-1:0] ra;
    logic          ra_nz, wb_hit, rel_hit;

    assign ra      = i_raddr[k*AW +: AW];
    assign ra_nz   = (ra != AW'(REG_ZERO));
    assign wb_hit  = wb_en & (i_wb_addr == ra);
    assign rel_hit = rel_en & (i_wb_addr == ra);

    assign o_rdata[k*XLEN +: XLEN] = (rst || !ra_nz) ? '0 :
                                     wb_hit          ? i_wb_data :
                                                       rf_q[ra];

    // The final outstanding write arriving this cycle is bypassed, not a hazard.
    assign o_raw[k] = ~rst & ra_nz & busy_vec[ra] & ~(rel_hit & last_vec[ra]);
  end

  // full_vec[0] is tied low, so x0 reservations are always accepted.
  assign o_issue_ready = ~rst & ~i_flush & ~full_vec[i_issue_rd];
  assign o_busy_any    = ~rst & (|busy_vec);

  // Debug taps look at the architectural state only.
  assign o_a0_zero = (rf_q[REG_A0] == '0);
  assign o_mret_a5 = i_mret ? rf_q[REG_A5] : '0;

endmodule

// File: tb/tb_ysyx_regfile_sb.sv
// Bench for ysyx_regfile_sb: behavioural model plus directed scenarios.
module tb_ysyx_regfile_sb;

  localparam int unsigned XLEN  = 32;
  localparam int unsigned NREGS = 32;
  localparam int unsigned AW    = 5;
  localparam int unsigned NRD   = 3;
  localparam int unsigned CNT_W = 2;
  localparam int          MAXC  = (1 << CNT_W) - 1;

  logic                clk = 1'b0;
  logic                rst = 1'b1;
  logic [NRD*AW-1:0]   raddr = '0;
  logic [NRD*XLEN-1:0] rdata;
  logic [NRD-1:0]      raw;
  logic                issue_valid = 1'b0;
  logic [AW-1:0]       issue_rd = '0;
  logic                issue_ready;
  logic                wb_wen = 1'b0;
  logic [AW-1:0]       wb_addr = '0;
  logic [XLEN-1:0]     wb_data = '0;
  logic                wb_release = 1'b0;
  logic                flush = 1'b0;
  logic                mret = 1'b0;
  logic [XLEN-1:0]     mret_a5;
  logic                a0_zero;
  logic                busy_any;

  always #5 clk = ~clk;

  ysyx_regfile_sb #(
    .XLEN  (XLEN),
    .NREGS (NREGS),
    .AW    (AW),
    .NRD   (NRD),
    .CNT_W (CNT_W)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .i_raddr       (raddr),
    .o_rdata       (rdata),
    .o_raw         (raw),
    .i_issue_valid (issue_valid),
    .i_issue_rd    (issue_rd),
    .o_issue_ready (issue_ready),
    .i_wb_wen      (wb_wen),
    .i_wb_addr     (wb_addr),
    .i_wb_data     (wb_data),
    .i_wb_release  (wb_release),
    .i_flush       (flush),
    .i_mret        (mret),
    .o_mret_a5     (mret_a5),
    .o_a0_zero     (a0_zero),
    .o_busy_any    (busy_any)
  );

  int vectors     = 0;
  int miscompares = 0;

  // Model state: register values and outstanding-write counts.
  logic [XLEN-1:0] m_rf  [NREGS] = '{default: '0};
  int              m_cnt [NREGS] = '{default: 0};

  task automatic cmp(input string name, input logic [XLEN-1:0] act, input logic [XLEN-1:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic exp_ready();
    return !rst && !flush && (issue_rd == 0 || m_cnt[issue_rd] < MAXC);
  endfunction

  function automatic logic [XLEN-1:0] exp_rdata(input logic [AW-1:0] a);
    if (rst || a == 0) return '0;
    if (wb_wen && wb_addr == a) return wb_data;
    return m_rf[a];
  endfunction

  // Hazard: writes still owed after whatever this cycle's writeback retires.
  function automatic logic exp_raw(input logic [AW-1:0] a);
    int owed;
    if (rst || a == 0) return 1'b0;
    owed = m_cnt[a] - ((wb_wen && wb_release && wb_addr == a) ? 1 : 0);
    return owed > 0;
  endfunction

  function automatic logic exp_busy();
    if (rst) return 1'b0;
    for (int i = 0; i < NREGS; i++) if (m_cnt[i] != 0) return 1'b1;
    return 1'b0;
  endfunction

  // Model update at each clock edge; reset clears everything immediately.
  always @(posedge clk or posedge rst) begin : model_upd
    int nc [NREGS];
    if (rst) begin
      for (int i = 0; i < NREGS; i++) begin
        m_rf[i]  <= '0;
        m_cnt[i] <= 0;
      end
    end else begin
      nc = m_cnt;
      if (issue_valid && exp_ready() && issue_rd != 0) nc[issue_rd] += 1;
      if (wb_wen && wb_release && wb_addr != 0) begin
        vectors++;
        if (m_cnt[wb_addr] == 0) begin
          miscompares++;
          $display("FAIL release_underflow x%0d: count 0, required nonzero", wb_addr);
        end else begin
          nc[wb_addr] -= 1;
        end
      end
      if (flush) nc = '{default: 0};
      if (wb_wen && wb_addr != 0) m_rf[wb_addr] <= wb_data;
      m_cnt <= nc;
    end
  end

  // Compare every output against the model on each falling edge.
  always @(negedge clk) begin
    for (int k = 0; k < NRD; k++) begin
      logic [AW-1:0] a;
      a = raddr[k*AW +: AW];
      cmp($sformatf("rdata%0d", k), rdata[k*XLEN +: XLEN], exp_rdata(a));
      cmp($sformatf("raw%0d", k), XLEN'(raw[k]), XLEN'(exp_raw(a)));
    end
    cmp("issue_ready", XLEN'(issue_ready), XLEN'(exp_ready()));
    cmp("busy_any", XLEN'(busy_any), XLEN'(exp_busy()));
    cmp("a0_zero", XLEN'(a0_zero), XLEN'(m_rf[10] == '0));
    cmp("mret_a5", mret_a5, mret ? m_rf[15] : '0);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Lands one unit after the falling edge, clear of the model compare.
  task automatic settle();
    #5;
  endtask

  task automatic idle();
    issue_valid = 1'b0;
    wb_wen      = 1'b0;
    wb_release  = 1'b0;
    flush       = 1'b0;
    mret        = 1'b0;
  endtask

  task automatic set_ra(input int k, input int a);
    raddr[k*AW +: AW] = AW'(a);
  endtask

  task automatic wb(input int a, input logic [XLEN-1:0] d, input logic rel);
    wb_wen     = 1'b1;
    wb_addr    = AW'(a);
    wb_data    = d;
    wb_release = rel;
  endtask

  initial begin
    // Reset: outputs held low even with a writeback presented.
    set_ra(0, 0); set_ra(1, 5); set_ra(2, 10);
    wb(5, 32'h55, 1'b0);
    tick(); settle();
    cmp("rst_rdata0", rdata[0*XLEN +: XLEN], 32'h0);
    cmp("rst_rdata1", rdata[1*XLEN +: XLEN], 32'h0);
    cmp("rst_rdata2", rdata[2*XLEN +: XLEN], 32'h0);
    cmp("rst_raw", XLEN'(raw), 32'h0);
    cmp("rst_a0_zero", XLEN'(a0_zero), 32'h1);
    cmp("rst_busy", XLEN'(busy_any), 32'h0);
    cmp("rst_ready", XLEN'(issue_ready), 32'h0);
    tick();
    rst = 1'b0;
    idle();

    // Reserve x5, then observe the hazard and its resolving writeback.
    issue_valid = 1'b1; issue_rd = 5;
    settle();
    cmp("ready_x5", XLEN'(issue_ready), 32'h1);
    tick();
    idle();
    settle();
    cmp("raw_x5_pending", XLEN'(raw[1]), 32'h1);
    cmp("busy_x5", XLEN'(busy_any), 32'h1);
    tick();
    wb(5, 32'hDEADBEEF, 1'b1);
    settle();
    cmp("bypass_x5", rdata[1*XLEN +: XLEN], 32'hDEADBEEF);
    cmp("raw_x5_final", XLEN'(raw[1]), 32'h0);
    tick();
    idle();
    settle();
    cmp("busy_cleared", XLEN'(busy_any), 32'h0);
    cmp("rf_x5", rdata[1*XLEN +: XLEN], 32'hDEADBEEF);

    // Saturate x7's counter.
    tick();
    issue_valid = 1'b1; issue_rd = 7; set_ra(0, 7);
    tick(); tick(); tick();
    settle();
    cmp("model_cnt7", 32'(m_cnt[7]), 32'd3);
    cmp("ready_x7_full", XLEN'(issue_ready), 32'h0);
    issue_valid = 1'b0; issue_rd = 8;
    #1;
    cmp("ready_x8", XLEN'(issue_ready), 32'h1);
    tick();
    issue_rd = 7;
    wb(7, 32'h77, 1'b1);
    settle();
    cmp("ready_x7_still_full", XLEN'(issue_ready), 32'h0);
    tick();
    idle();
    settle();
    cmp("ready_x7_restored", XLEN'(issue_ready), 32'h1);
    tick();
    wb(7, 32'h78, 1'b1);
    tick();
    tick();
    idle();

    // Simultaneous reserve and release on x3.
    issue_valid = 1'b1; issue_rd = 3; set_ra(0, 3);
    tick();
    wb(3, 32'h33, 1'b1);
    settle();
    cmp("raw_x3_bypassed", XLEN'(raw[0]), 32'h0);
    cmp("bypass_x3", rdata[0*XLEN +: XLEN], 32'h33);
    tick();
    idle();
    settle();
    cmp("raw_x3_still", XLEN'(raw[0]), 32'h1);
    cmp("rf_x3", rdata[0*XLEN +: XLEN], 32'h33);
    cmp("model_cnt3", 32'(m_cnt[3]), 32'd1);
    tick();
    wb(3, 32'h34, 1'b1);
    tick();
    idle();

    // Flush with pending x4 and x6 and a concurrent writeback.
    issue_valid = 1'b1; issue_rd = 4;
    tick();
    issue_rd = 6;
    tick();
    issue_rd = 9; flush = 1'b1; set_ra(0, 4); set_ra(1, 6);
    wb(4, 32'h11, 1'b1);
    settle();
    cmp("ready_flush", XLEN'(issue_ready), 32'h0);
    tick();
    idle();
    settle();
    cmp("busy_after_flush", XLEN'(busy_any), 32'h0);
    cmp("rf_x4_flush", rdata[0*XLEN +: XLEN], 32'h11);
    cmp("raw_x6_flush", XLEN'(raw[1]), 32'h0);

    // Debug taps.
    tick();
    wb(10, 32'h5, 1'b0);
    settle();
    cmp("a0_not_bypassed", XLEN'(a0_zero), 32'h1);
    tick();
    wb(10, 32'h0, 1'b0);
    settle();
    cmp("a0_nonzero", XLEN'(a0_zero), 32'h0);
    tick();
    wb(15, 32'h80000000, 1'b0);
    tick();
    idle();
    settle();
    cmp("a0_zero_again", XLEN'(a0_zero), 32'h1);
    mret = 1'b1;
    #1;
    cmp("mret_a5_on", mret_a5, 32'h80000000);
    mret = 1'b0;
    #1;
    cmp("mret_a5_off", mret_a5, 32'h0);

    // Writes to x0 are dropped.
    tick();
    set_ra(0, 0);
    wb(0, 32'h123, 1'b1);
    settle();
    cmp("x0_bypass", rdata[0*XLEN +: XLEN], 32'h0);
    tick();
    idle();
    settle();
    cmp("x0_read", rdata[0*XLEN +: XLEN], 32'h0);
    cmp("x0_raw", XLEN'(raw[0]), 32'h0);

    // Reset mid-cycle discards the in-flight write and reservation.
    tick();
    issue_valid = 1'b1; issue_rd = 2; set_ra(0, 9);
    wb(9, 32'hAB, 1'b1);
    #2;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    idle();
    settle();
    cmp("rst_drop_x9", rdata[0*XLEN +: XLEN], 32'h0);
    cmp("rst_drop_busy", XLEN'(busy_any), 32'h0);
    tick();
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/ysyx_regfile_sb.md
Name: ysyx_regfile_sb

Overview:
- Parametrised integer register file with an integrated per-register pending-write scoreboard, for the pipelined core.
- Sits between decode/issue and writeback.
- Provides NRD combinational read ports with write-to-read bypass, and RAW hazard flags per read port.
- Issue-side handshake reserves destination registers; writeback releases them; flush drops all reservations.
- Keeps the zero-register, a0==0 and a5 debug taps of the single-cycle file.

Parameters:
- XLEN, 32, data width.
- NREGS, 32, architectural register count (16 for RV32E); power of two.
- AW, $clog2(NREGS), register address width.
- NRD, 2, number of read ports (1..4).
- CNT_W, 2, width of per-register pending counter; max outstanding writes per reg = 2^CNT_W-1.

Ports:
- clk  in  1  core clock
- rst  in  1  asynchronous active-high reset
- i_raddr  in  NRD*AW  read addresses, port k at [k*AW +: AW]
- o_rdata  out  NRD*XLEN  read data, port k at [k*XLEN +: XLEN]
- o_raw  out  NRD  port k source has an unresolved pending write
- i_issue_valid  in  1  issue requests reservation of i_issue_rd
- i_issue_rd  in  AW  destination to reserve
- o_issue_ready  out  1  reservation accepted when valid&ready
- i_wb_wen  in  1  writeback valid
- i_wb_addr  in  AW  writeback destination
- i_wb_data  in  XLEN  writeback data
- i_wb_release  in  1  writeback also retires one reservation (0 for CSR/unreserved writes)
- i_flush  in  1  clear all pending counters (pipeline squash)
- i_mret  in  1  gates debug a5 tap
- o_mret_a5  out  XLEN  rf[15] when i_mret, else 0
- o_a0_zero  out  1  rf[10]==0
- o_busy_any  out  1  any pending counter nonzero

Behaviour:
- Reset (async, rst=1): all rf entries 0, all counters 0. While in reset: o_issue_ready=0, o_busy_any=0, o_raw=0, o_a0_zero=1, o_rdata=0. Reset mid-operation discards everything, including an in-flight write on that edge.
- Register 0: never written and never reserved. rd=0 issue is accepted, counter untouched. Read of x0 returns 0 with o_raw=0. Writeback to x0 has no effect and releases nothing.
- Write:
  - On posedge, if i_wb_wen and i_wb_addr!=0, rf[i_wb_addr] <= i_wb_data.
  - Bypass: the read is combinational. If i_wb_wen and i_wb_addr==raddr_k!=0, o_rdata_k = i_wb_data in the same cycle, otherwise rf[raddr_k].
- Counter update per register r!=0, per cycle:
  - inc = issue fire (valid&ready) & rd==r
  - dec = i_wb_wen & i_wb_release & wb_addr==r & cnt[r]!=0
  - Next value = cnt+inc-dec, so simultaneous inc and dec leaves it unchanged.
  - A dec at cnt==0 is ignored. The bench flags it as an assertion error.
- Flush:
  - All counters go to 0 next cycle. Flush has priority over inc/dec in the same cycle; the writeback data is still written.
  - o_issue_ready=0 during i_flush.
- o_issue_ready = !rst & !i_flush & (i_issue_rd==0 | cnt[i_issue_rd] != max). Not dependent on i_issue_valid.
- o_raw_k = raddr_k!=0 & cnt[raddr_k]!=0 & !(dec on raddr_k this cycle & cnt==1). A final writeback being bypassed is not a hazard.
- Read ports are fully combinational, with no latency. Updates to counters and rf are visible from the next cycle.
- o_a0_zero and o_mret_a5 read the architectural array, not bypassed.
- Widths: all counters CNT_W unsigned; saturation is prevented by ready, never by wrap.

Decomposition:
- Shared package/defines: XLEN, NREGS, the AW derivation, the register index constants REG_ZERO=0, REG_A0=10, REG_A5=15, and a default CNT_W.
- One natural sub-module, ysyx_sb_counter: a single register's pending counter with inc/dec/flush/max-detect, instantiated NREGS-1 times via generate.
- Array and bypass mux stay in the top module.

Test Plan:
- Reset then read ports with raddr=0,5,10 -> rdata all 0, o_raw=0, o_a0_zero=1, o_busy_any=0.
- Issue rd=5; next cycle read x5 -> o_raw=1. Writeback x5=0xDEADBEEF with release, same cycle read x5 -> rdata=0xDEADBEEF, o_raw=0. Following cycle cnt=0, o_busy_any=0.
- CNT_W=2: issue rd=7 three times -> o_issue_ready drops to 0 for rd=7 and stays 1 for rd=8. One release writeback restores ready next cycle.
- Same-cycle issue rd=3 and release writeback x3 with cnt=1 -> cnt stays 1, o_raw for x3 remains 1 next cycle, rf[3] holds the written data.
- Pending x4,x6 -> assert i_flush together with writeback x4=0x11 -> next cycle all counters 0, rf[4]=0x11, o_issue_ready=0 during the flush cycle.
- Write x10=0, x15=0x80000000 -> o_a0_zero=1; i_mret=1 -> o_mret_a5=0x80000000; i_mret=0 -> 0. Writeback x0=0x123 -> read x0 still 0.
